uart_word_loader: RTL and testbench

Downstream consumer of the UART receiver's AXI4-Stream byte output. It parses a framed download (sync byte, 16-bit word count, payload), packs payload bytes MSB-first into 32-bit words, and writes them to instruction/data memory. It holds the processor in reset until a load completes. It sits between the UART receiver and the memory write port of the processor.

---
 rtl/uart_loader_pkg.sv | 25 ++
 rtl/uart_word_packer.sv | 53 +++++
 rtl/uart_word_loader.sv | 206 ++++++++++++++++++++
 tb/tb_uart_word_loader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_loader_pkg.sv
// Shared constants and state encoding for the UART word loader.
// Checksum state is only reachable when UART_LOADER_CHECKSUM_EN is defined.
package uart_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam logic [7:0] SYNC_DEFAULT   = 8'hA5;
    localparam int         WORD_W         = 32;
    localparam int         BYTES_PER_WORD = 4;
    localparam int         PHASE_W        = $clog2(BYTES_PER_WORD);

    // States in which a frame is open and the idle timeout runs.
    function automatic logic in_frame(input state_t s);
        return (s == ST_LEN_HI) || (s == ST_LEN_LO) ||
               (s == ST_DATA)   || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/uart_word_packer.sv
// Packs payload bytes MSB-first into 32-bit words.
// Emits a registered word_valid pulse aligned with the finished word.
module uart_word_packer
    import uart_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    output logic              last_byte_o,
    output logic              word_valid_o,
    output logic [WORD_W-1:0] word_o
);

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [WORD_W-1:0]  shift_q, shift_d;
    logic               valid_q, valid_d;

    assign last_byte_o =
        byte_valid_i && (phase_q == PHASE_W'(BYTES_PER_WORD - 1));

    always_comb begin
        phase_d = phase_q;
        shift_d = shift_q;
        valid_d = last_byte_o;
        if (clear_i) begin
            phase_d = '0;
            shift_d = '0;
            valid_d = 1'b0;
        end else if (byte_valid_i) begin
            // Phase wraps to zero after the fourth byte of a word.
            phase_d = phase_q + 1'b1;
            shift_d = {shift_q[WORD_W-9:0], byte_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
        end
    end

    assign word_valid_o = valid_q;
    assign word_o       = shift_q;

endmodule

// File: rtl/uart_word_loader.sv
// Framed UART download into word memory; holds the core in reset until done.
// Define UART_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module uart_word_loader
    import uart_loader_pkg::*;
#(
    parameter int         ADDR_WIDTH     = 10,
    parameter int         BASE_ADDR      = 0,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            input_axis_tdata,
    input  logic                  input_axis_tvalid,
    output logic                  input_axis_tready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_W-1:0]     mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  proc_rst
);

    localparam logic [31:0] DEPTH = 32'd1 << ADDR_WIDTH;
    localparam int          TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

`ifdef UART_LOADER_CHECKSUM_EN
    localparam state_t ST_END = ST_CSUM;
`else
    localparam state_t ST_END = ST_DONE;
`endif

    state_t                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [15:0]           index_q, index_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  error_q, error_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    logic        acc;
    logic        frame_start;
    logic        timeout;
    logic        fail;
    logic        pk_valid;
    logic        last_byte;
    logic        last_word;
    logic        word_valid;
    logic [31:0] word;
    logic [15:0] len_w;

    assign acc   = input_axis_tvalid && !rst;
    assign len_w = {len_q[15:8], input_axis_tdata};

    assign frame_start = acc && (input_axis_tdata == SYNC_BYTE) &&
                         ((state_q == ST_IDLE) || (state_q == ST_DONE));

    assign timeout   = in_frame(state_q) && !acc && (tmo_q == TMO_LAST);
    assign pk_valid  = acc && (state_q == ST_DATA);
    assign last_word = last_byte && ((index_q + 16'd1) == len_q);

    uart_word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (frame_start),
        .byte_valid_i (pk_valid),
        .byte_i       (input_axis_tdata),
        .last_byte_o  (last_byte),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (frame_start) begin
            csum_d = '0;
        end else if (pk_valid) begin
            csum_d = csum_q ^ input_axis_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        fail    = 1'b0;
        if (timeout) begin
            state_d = ST_IDLE;
            fail    = 1'b1;
        end else if (acc) begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (input_axis_tdata == SYNC_BYTE) begin
                        state_d = ST_LEN_HI;
                    end
                end
                ST_LEN_HI: state_d = ST_LEN_LO;
                ST_LEN_LO: begin
                    if ({16'd0, len_w} > DEPTH) begin
                        state_d = ST_IDLE;
                        fail    = 1'b1;
                    end else if (len_w == 16'd0) begin
                        state_d = ST_END;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (last_word) begin
                        state_d = ST_END;
                    end
                end
`ifdef UART_LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (input_axis_tdata == csum_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_IDLE;
                        fail    = 1'b1;
                    end
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output logic.
    always_comb begin
        busy     = in_frame(state_q);
        done     = (state_q == ST_DONE);
        proc_rst = (state_q != ST_DONE);
    end

    // Frame datapath: length, word index, write address, timeout, status.
    always_comb begin
        len_d   = len_q;
        index_d = index_q;
        addr_d  = addr_q;
        error_d = error_q;
        tmo_d   = (acc || !in_frame(state_q)) ? '0 : tmo_q + 1'b1;
        if (frame_start) begin
            len_d   = '0;
            index_d = '0;
            error_d = 1'b0;
        end else begin
            if (fail) begin
                error_d = 1'b1;
            end
            if (acc && (state_q == ST_LEN_HI)) begin
                len_d[15:8] = input_axis_tdata;
            end
            if (acc && (state_q == ST_LEN_LO)) begin
                len_d[7:0] = input_axis_tdata;
            end
            if (last_byte) begin
                addr_d  = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(index_q);
                index_d = index_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q   <= '0;
            index_q <= '0;
            addr_q  <= ADDR_WIDTH'(BASE_ADDR);
            error_q <= 1'b0;
            tmo_q   <= '0;
        end else begin
            len_q   <= len_d;
            index_q <= index_d;
            addr_q  <= addr_d;
            error_q <= error_d;
            tmo_q   <= tmo_d;
        end
    end

    assign input_axis_tready = !rst;
    assign mem_we            = word_valid;
    assign mem_addr          = addr_q;
    assign mem_wdata         = word;
    assign error             = error_q;

endmodule

// File: tb/tb_uart_word_loader.sv
// Randomized frame bench for uart_word_loader against a queue-based model.
// Honours UART_LOADER_CHECKSUM_EN for the trailing checksum byte.
module tb_uart_word_loader;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;
    localparam int BASE  = 1020;
    localparam int TMO   = 50;
    localparam logic [7:0] SYNC = 8'hA5;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    tdata = '0;
    logic          tvalid = 1'b0;
    logic          tready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          busy, done, error, proc_rst;

    int n_chk = 0;
    int n_err = 0;

    wr_t        exp_q[$];
    logic [7:0] pay[$];

    always #5 clk = ~clk;

    uart_word_loader #(
        .ADDR_WIDTH     (AW),
        .BASE_ADDR      (BASE),
        .TIMEOUT_CYCLES (TMO),
        .SYNC_BYTE      (SYNC)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .input_axis_tdata  (tdata),
        .input_axis_tvalid (tvalid),
        .input_axis_tready (tready),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .busy              (busy),
        .done              (done),
        .error             (error),
        .proc_rst          (proc_rst)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every observed write must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (mem_we) begin
            if (exp_q.size() == 0) begin
                chk("we_unexpected", 64'(mem_we), 64'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 64'(mem_addr), 64'(e.addr));
                chk("wr_data", 64'(mem_wdata), 64'(e.data));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        if (gap) repeat ($urandom_range(0, 3)) tick();
        tdata  = b;
        tvalid = 1'b1;
        tick();
        tvalid = 1'b0;
        tdata  = 8'($urandom);
    endtask

    task automatic fill_rand(input int nw, input bit all_sync);
        pay.delete();
        for (int i = 0; i < nw * 4; i++) begin
            pay.push_back(all_sync ? SYNC : 8'($urandom));
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_tready"}, 64'(tready), 64'd0);
        chk({tag, "_we"}, 64'(mem_we), 64'd0);
        chk({tag, "_addr"}, 64'(mem_addr), 64'(BASE % DEPTH));
        chk({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
        chk({tag, "_status"}, {60'd0, busy, done, error, proc_rst}, 64'h1);
    endtask

    task automatic send_header(input int n, input bit gap);
        logic [15:0] nn;
        nn = 16'(n);
        send_byte(SYNC, gap);
        chk("sync_status", {60'd0, busy, done, error, proc_rst}, 64'h9);
        send_byte(nn[15:8], gap);
        send_byte(nn[7:0], gap);
    endtask

    // Sends the payload in pay[] as a complete, valid frame.
    task automatic good_frame(input bit gap);
        int         nw;
        logic [7:0] cs;
        nw = pay.size() / 4;
        cs = '0;
        for (int w = 0; w < nw; w++) begin
            wr_t e;
            e.addr = (BASE + w) % DEPTH;
            e.data = {pay[4*w], pay[4*w+1], pay[4*w+2], pay[4*w+3]};
            exp_q.push_back(e);
        end
        foreach (pay[i]) cs ^= pay[i];
        send_header(nw, gap);
        foreach (pay[i]) send_byte(pay[i], gap);
`ifdef UART_LOADER_CHECKSUM_EN
        send_byte(cs, gap);
`endif
        chk("end_status", {60'd0, busy, done, error, proc_rst}, 64'h4);
        chk("end_we", 64'(mem_we), 64'(nw > 0));
    endtask

    initial begin
        repeat (3) tick();
        chk_reset_vals("rst");
        rst = 1'b0;
        #1;
        chk("tready_up", 64'(tready), 64'd1);

        // Basic two-word load.
        pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
        good_frame(1'b0);

        // Junk ahead of the sync byte is ignored.
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h5A, 1'b0);
        chk("junk_done_held", 64'(done), 64'd1);
        fill_rand(1, 1'b0);
        good_frame(1'b1);

        // Payload made of sync bytes is plain data.
        fill_rand(2, 1'b1);
        good_frame(1'b0);

        // Randomized frames, including empty and wrapping ones.
        for (int f = 0; f < 10; f++) begin
            int nb;
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                logic [7:0] jb;
                jb = 8'($urandom);
                if (jb == SYNC) jb = 8'h00;
                send_byte(jb, 1'b1);
            end
            nb = (f == 0) ? 0 : int'($urandom_range(1, 9));
            fill_rand(nb, 1'b0);
            good_frame(1'(f % 2));
        end

        // Oversize length: N = DEPTH + 1.
        send_header(DEPTH + 1, 1'b0);
        chk("over_status", {60'd0, busy, done, error, proc_rst}, 64'h3);

        // Largest legal frame fills the whole memory.
        fill_rand(DEPTH, 1'b0);
        good_frame(1'b0);

        // Timeout inside a partial word.
        send_header(1, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        repeat (TMO - 1) tick();
        chk("tmo_early", {60'd0, busy, done, error, proc_rst}, 64'h9);
        tick();
        chk("tmo_hit", {60'd0, busy, done, error, proc_rst}, 64'h3);
        repeat (4) tick();

`ifdef UART_LOADER_CHECKSUM_EN
        // Bad checksum: word still written, load fails.
        exp_q.push_back('{BASE % DEPTH, 32'h11223344});
        send_header(1, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        send_byte(8'h00, 1'b0);
        chk("csum_bad", {60'd0, busy, done, error, proc_rst}, 64'h3);
        pay = '{8'h11, 8'h22, 8'h33, 8'h44};
        good_frame(1'b0);
`endif

        // Reset pulse after two data bytes aborts the frame.
        send_header(2, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        rst = 1'b1;
        tick();
        chk_reset_vals("midrst");
        rst = 1'b0;
        repeat (2) tick();
        fill_rand(2, 1'b0);
        good_frame(1'b1);

        repeat (4) tick();
        chk("wr_missing", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
